// File: rtl/dna_port_emu_if.sv
// dna_port_emu_if: DNA serial port between a reader (master) and the emulator (slave).
//   dna_clk/dna_read/dna_shift/dna_din : reader -> emulator serial controls
//   dna_dout                           : emulator -> reader serial data (shift register bit 56)
//   shift_count/id_loaded/early_read   : emulator status
interface dna_port_emu_if;
    logic       dna_clk;
    logic       dna_read;
    logic       dna_shift;
    logic       dna_din;
    logic       dna_dout;
    logic [5:0] shift_count;
    logic       id_loaded;
    logic       early_read;

    modport master (
        output dna_clk, dna_read, dna_shift, dna_din,
        input  dna_dout, shift_count, id_loaded, early_read
    );

    modport slave (
        input  dna_clk, dna_read, dna_shift, dna_din,
        output dna_dout, shift_count, id_loaded, early_read
    );
endinterface

// File: rtl/dna_port_emu.sv
// dna_port_emu: emulates the FPGA device-DNA serial port, serving a 57-bit ID MSB-first.
// The reader's dna_clk is sampled on clk (2-FF synchronizer) and edge-detected.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   dna        : dna_port_emu_if.slave (serial controls in, dout/status out)
//   id_in, id_valid, id_ready : live-ID load handshake (only with DNA_LIVE_ID_EN)
// Optional feature macro: DNA_LIVE_ID_EN (ID loaded once per reset from id_in).
module dna_port_emu #(
    parameter logic [56:0] DNA_VALUE = 57'h0AAAAAAAAAAAAAA
) (
    input  logic          clk,
    input  logic          reset,
    dna_port_emu_if.slave dna
`ifdef DNA_LIVE_ID_EN
    ,
    input  logic [56:0]   id_in,
    input  logic          id_valid,
    output logic          id_ready
`endif
);
    localparam int unsigned ID_W  = 57;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned SYN_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(ID_W);

    typedef enum logic [1:0] {UNLOADED, IDLE, SHIFTING, DRAINED} state_t;

`ifdef DNA_LIVE_ID_EN
    localparam state_t RST_STATE  = UNLOADED;
    localparam logic   RST_LOADED = 1'b0;
`else
    localparam state_t RST_STATE  = IDLE;
    localparam logic   RST_LOADED = 1'b1;
`endif

    // Synchronizer bit order: {dna_clk, dna_read, dna_shift, dna_din}
    logic [SYN_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic             clk_prev_q, clk_prev_d;
    state_t           state_q, state_d;
    logic [ID_W-1:0]  sr_q, sr_d, id_reg_q, id_reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             loaded_q, loaded_d;
    logic             early_q, early_d;
`ifdef DNA_LIVE_ID_EN
    logic             ready_q, ready_d;
`endif

    logic clk_rise, rd_ev, sh_ev, din_s;

    // Edge and control bits all come from the second stage so they are coherent.
    assign clk_rise = sync2_q[3] & ~clk_prev_q;
    assign rd_ev    = clk_rise & sync2_q[2];
    assign sh_ev    = clk_rise & ~sync2_q[2] & sync2_q[1];
    assign din_s    = sync2_q[0];

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            clk_prev_q <= 1'b0;
            state_q    <= RST_STATE;
            sr_q       <= '0;
            id_reg_q   <= DNA_VALUE;
            cnt_q      <= '0;
            dout_q     <= 1'b0;
            loaded_q   <= RST_LOADED;
            early_q    <= 1'b0;
`ifdef DNA_LIVE_ID_EN
            ready_q    <= 1'b1;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            sr_q       <= sr_d;
            id_reg_q   <= id_reg_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            loaded_q   <= loaded_d;
            early_q    <= early_d;
`ifdef DNA_LIVE_ID_EN
            ready_q    <= ready_d;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        sync1_d    = {dna.dna_clk, dna.dna_read, dna.dna_shift, dna.dna_din};
        sync2_d    = sync1_q;
        clk_prev_d = sync2_q[3];
        state_d    = state_q;
        sr_d       = sr_q;
        id_reg_d   = id_reg_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        early_d    = early_q;

`ifdef DNA_LIVE_ID_EN
        // One-shot ID capture; a read in this same cycle still sees loaded_q=0.
        if (state_q == UNLOADED && id_valid && ready_q) begin
            id_reg_d = id_in;
            loaded_d = 1'b1;
            state_d  = IDLE;
        end
`endif

        if (rd_ev) begin
            if (loaded_q) begin
                sr_d    = id_reg_q;
                cnt_d   = '0;
                state_d = SHIFTING;
            end else begin
                sr_d    = '0;
                early_d = 1'b1;
            end
        end else if (sh_ev) begin
            sr_d  = {sr_q[ID_W-2:0], din_s};
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
            if (state_q == SHIFTING && cnt_d >= CNT_DONE) begin
                state_d = DRAINED;
            end
        end

        // dout tracks the shift register MSB in the same cycle it changes.
        dout_d = sr_d[ID_W-1];
`ifdef DNA_LIVE_ID_EN
        ready_d = (state_d == UNLOADED);
`endif
    end

    assign dna.dna_dout    = dout_q;
    assign dna.shift_count = cnt_q;
    assign dna.id_loaded   = loaded_q;
    assign dna.early_read  = early_q;
`ifdef DNA_LIVE_ID_EN
    assign id_ready        = ready_q;
`endif
endmodule

// File: tb/tb_dna_port_emu.sv
// tb_dna_port_emu: directed, table-driven bench for dna_port_emu (both macro builds).
module tb_dna_port_emu;
    localparam logic [56:0] DNA_VAL = 57'h0AAAAAAAAAAAAAA;
    localparam logic [56:0] LIVE_ID = 57'h123456789ABCDEF;

    typedef struct {
        bit       rd;
        bit       sh;
        bit       din;
        bit       exp_dout;
        bit [5:0] exp_cnt;
    } vec_t;

    logic clk;
    logic reset;
    dna_port_emu_if dna_if();

`ifdef DNA_LIVE_ID_EN
    logic [56:0] id_in;
    logic        id_valid;
    logic        id_ready;
`endif

    dna_port_emu #(.DNA_VALUE(DNA_VAL)) dut (
        .clk     (clk),
        .reset   (reset),
        .dna     (dna_if)
`ifdef DNA_LIVE_ID_EN
        ,
        .id_in   (id_in),
        .id_valid(id_valid),
        .id_ready(id_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [56:0] id_exp;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One reader DNA clock period: controls change 1 cycle after the fall,
    // rise after lo cycles low, then hi cycles high. Sample afterwards.
    task automatic dna_cycle(input bit rd, input bit sh, input bit d, input int lo, input int hi);
        dna_if.dna_clk = 1'b0;
        @(negedge clk);
        dna_if.dna_read  = rd;
        dna_if.dna_shift = sh;
        dna_if.dna_din   = d;
        repeat (lo - 1) @(negedge clk);
        dna_if.dna_clk = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef DNA_LIVE_ID_EN
    task automatic load_id(input logic [56:0] v);
        id_in    = v;
        id_valid = 1'b1;
        @(negedge clk);
        chk("id_ready_drop", 64'(id_ready), 64'd0);
        chk("id_loaded_set", 64'(dna_if.id_loaded), 64'd1);
        id_valid = 1'b0;
        id_in    = '0;
    endtask
`endif

    initial begin
        logic [56:0] got;
        dna_if.dna_clk   = 1'b0;
        dna_if.dna_read  = 1'b0;
        dna_if.dna_shift = 1'b0;
        dna_if.dna_din   = 1'b0;
`ifdef DNA_LIVE_ID_EN
        id_in    = '0;
        id_valid = 1'b0;
`endif
        id_exp = DNA_VAL;
        do_reset();

        // Reset state
        chk("rst_dout", 64'(dna_if.dna_dout), 64'd0);
        chk("rst_cnt", 64'(dna_if.shift_count), 64'd0);
        chk("rst_early", 64'(dna_if.early_read), 64'd0);
`ifdef DNA_LIVE_ID_EN
        chk("rst_loaded", 64'(dna_if.id_loaded), 64'd0);
        chk("rst_ready", 64'(id_ready), 64'd1);
        // Read before the ID is present is treated as early
        dna_cycle(1'b1, 1'b0, 1'b1, 8, 8);
        chk("early_dout", 64'(dna_if.dna_dout), 64'd0);
        chk("early_flag", 64'(dna_if.early_read), 64'd1);
        chk("early_loaded", 64'(dna_if.id_loaded), 64'd0);
        load_id(LIVE_ID);
        id_exp = LIVE_ID;
`else
        chk("rst_loaded", 64'(dna_if.id_loaded), 64'd1);
`endif

        // Table: read + 57 shifts (din=0), then read + 70 shifts (din=1)
        vecs.push_back('{1'b1, 1'b0, 1'b0, id_exp[56], 6'd0});
        for (int k = 1; k <= 57; k++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, (k < 57) ? id_exp[56-k] : 1'b0, 6'(k)});
        vecs.push_back('{1'b1, 1'b0, 1'b1, id_exp[56], 6'd0});
        for (int k = 1; k <= 70; k++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, (k < 57) ? id_exp[56-k] : 1'b1,
                             (k > 63) ? 6'd63 : 6'(k)});

        for (int i = 0; i < vecs.size(); i++) begin
            dna_cycle(vecs[i].rd, vecs[i].sh, vecs[i].din, 8, 8);
            chk($sformatf("vec%0d_dout", i), 64'(dna_if.dna_dout), 64'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_cnt", i), 64'(dna_if.shift_count), 64'(vecs[i].exp_cnt));
        end

        // Read and shift together: read wins
        dna_cycle(1'b1, 1'b1, 1'b1, 8, 8);
        chk("rdsh_dout", 64'(dna_if.dna_dout), 64'(id_exp[56]));
        chk("rdsh_cnt", 64'(dna_if.shift_count), 64'd0);
        dna_cycle(1'b0, 1'b1, 1'b0, 8, 8);
        chk("rdsh_next_dout", 64'(dna_if.dna_dout), 64'(id_exp[55]));
        chk("rdsh_next_cnt", 64'(dna_if.shift_count), 64'd1);

        // Reset mid-transfer
        dna_cycle(1'b1, 1'b0, 1'b0, 8, 8);
        for (int k = 0; k < 20; k++) dna_cycle(1'b0, 1'b1, 1'b1, 8, 8);
        chk("pre_rst_cnt", 64'(dna_if.shift_count), 64'd20);
        dna_if.dna_clk = 1'b0;
        do_reset();
        chk("midrst_dout", 64'(dna_if.dna_dout), 64'd0);
        chk("midrst_cnt", 64'(dna_if.shift_count), 64'd0);
        chk("midrst_early", 64'(dna_if.early_read), 64'd0);
`ifdef DNA_LIVE_ID_EN
        chk("midrst_loaded", 64'(dna_if.id_loaded), 64'd0);
        load_id(LIVE_ID);
`endif
        dna_cycle(1'b1, 1'b0, 1'b0, 8, 8);
        chk("postrst_b56", 64'(dna_if.dna_dout), 64'(id_exp[56]));
        dna_cycle(1'b0, 1'b1, 1'b0, 8, 8);
        chk("postrst_b55", 64'(dna_if.dna_dout), 64'(id_exp[55]));

        // Fastest reader clock (clk/8): full ID, no missed or doubled shifts
        got = '0;
        dna_cycle(1'b1, 1'b0, 1'b0, 4, 4);
        got[56] = dna_if.dna_dout;
        for (int k = 1; k <= 57; k++) begin
            dna_cycle(1'b0, 1'b1, 1'(k & 1), 4, 4);
            if (k < 57) got[56-k] = dna_if.dna_dout;
        end
        chk("fast_id", 64'(got), 64'(id_exp));
        chk("fast_cnt", 64'(dna_if.shift_count), 64'd57);
        chk("fast_din_out", 64'(dna_if.dna_dout), 64'd1);
        chk("final_early", 64'(dna_if.early_read), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
